segre_hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the Segre 5-stage core (IF/ID/EX/MEM/WB). It replaces combinational stage-matching with a per-register in-flight-write scoreboard and adds an optional forwarding mode that stalls only on load-use. It also adds a miss FSM that holds the pipeline across multi-cycle I-cache and D-cache refills, branch-flush handling and a stall-cycle counter. It drives every per-stage `block_*` and `inject_nops_*` control.

---
 rtl/segre_pkg.sv | 43 ++++
 rtl/segre_scoreboard.sv | 57 +++++
 rtl/segre_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_segre_hazard_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types for the Segre hazard controller.
// Holds the forwarding select, the miss FSM state and the register id width.
package segre_pkg;

    localparam int REG_SIZE = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_MEM  = 2'd2,
        FWD_WB   = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        IC_MISS   = 2'd1,
        DC_MISS   = 2'd2,
        DC_REPLAY = 2'd3
    } miss_state_e;

    // Youngest in-flight producer of src wins: EX, then MEM, then WB.
    function automatic fwd_sel_e fwd_pick(
        input logic [REG_SIZE-1:0] src,
        input logic                ex_w,
        input logic [REG_SIZE-1:0] ex_d,
        input logic                mem_w,
        input logic [REG_SIZE-1:0] mem_d,
        input logic                wb_w,
        input logic [REG_SIZE-1:0] wb_d
    );
        if (src == '0)
            return FWD_NONE;
        else if (ex_w && ex_d == src)
            return FWD_EX;
        else if (mem_w && mem_d == src)
            return FWD_MEM;
        else if (wb_w && wb_d == src)
            return FWD_WB;
        else
            return FWD_NONE;
    endfunction

endpackage

// File: rtl/segre_scoreboard.sv
// Per-register count of writes in flight between issue (ID) and retire (WB).
// Ports: issue/issue_dst, retire/retire_dst, src_a/src_b -> busy_a/busy_b.
module segre_scoreboard
    import segre_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic                issue,
    input  logic [REG_SIZE-1:0] issue_dst,
    input  logic                retire,
    input  logic [REG_SIZE-1:0] retire_dst,
    input  logic [REG_SIZE-1:0] src_a,
    input  logic [REG_SIZE-1:0] src_b,
    output logic                busy_a,
    output logic                busy_b
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_INFLIGHT);

    logic [CW-1:0]       cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;

    always_comb begin
        inc = '0;
        dec = '0;
        if (issue)
            inc[issue_dst] = 1'b1;
        if (retire)
            dec[retire_dst] = 1'b1;
    end

    // Issue and retire on the same register cancel out.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                assert (!(inc[r] && !dec[r] && cnt[r] == CMAX));
                assert (!(dec[r] && !inc[r] && cnt[r] == '0));
                if (inc[r] && !dec[r] && cnt[r] != CMAX)
                    cnt[r] <= cnt[r] + CW'(1);
                else if (dec[r] && !inc[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CW'(1);
            end
        end
    end

    assign busy_a = (src_a != '0) && (cnt[src_a] != '0);
    assign busy_b = (src_b != '0) && (cnt[src_b] != '0);

endmodule

// File: rtl/segre_hazard_ctrl.sv
// Pipeline hazard controller: data hazards, cache-miss holds, flush, stall count.
// Inputs: per-stage valid/we/dst, ID sources, cache status, flush.
// Outputs: block_*/inject_nops_* per stage, fwd_a/fwd_b, stall_cnt.
module segre_hazard_ctrl
    import segre_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int MAX_INFLIGHT = 3,
    parameter int FWD_EN       = 1,
    parameter int CNT_W        = 32
) (
    input  logic                clk_i,
    input  logic                rsn_i,
    input  logic                valid_if_i,
    input  logic                ic_hit_i,
    input  logic                ic_fill_i,
    input  logic                valid_id_i,
    input  logic                we_id_i,
    input  logic [REG_SIZE-1:0] src_a_id_i,
    input  logic [REG_SIZE-1:0] src_b_id_i,
    input  logic [REG_SIZE-1:0] dst_id_i,
    input  logic                valid_ex_i,
    input  logic                we_ex_i,
    input  logic                load_ex_i,
    input  logic [REG_SIZE-1:0] dst_ex_i,
    input  logic                valid_mem_i,
    input  logic                we_mem_i,
    input  logic                dc_miss_i,
    input  logic                dc_fill_i,
    input  logic [REG_SIZE-1:0] dst_mem_i,
    input  logic                valid_wb_i,
    input  logic                we_wb_i,
    input  logic [REG_SIZE-1:0] dst_wb_i,
    input  logic                flush_i,
    output logic                block_if_o,
    output logic                block_id_o,
    output logic                block_ex_o,
    output logic                block_mem_o,
    output logic                inject_nops_id_o,
    output logic                inject_nops_ex_o,
    output logic                inject_nops_wb_o,
    output fwd_sel_e            fwd_a_o,
    output fwd_sel_e            fwd_b_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);

    miss_state_e state, state_n;
    logic ic_pend, ic_pend_n;
    logic d_miss, i_miss, dc_stall, ic_stall, flush_eff;
    logic busy_a, busy_b, ld_use, raw_haz, hazard;
    logic issue, retire, block_wb;
    logic ex_w, mem_w, wb_w;

    assign block_wb = 1'b0;
    assign d_miss   = valid_mem_i & dc_miss_i;
    assign i_miss   = valid_if_i & ~ic_hit_i;

    assign dc_stall = (state == DC_MISS) | (state == DC_REPLAY) | d_miss;
    assign ic_stall = (state == IC_MISS) | ((state == IDLE) & i_miss);

    // A pending D-miss holds everything, so the flush waits for release.
    assign flush_eff = flush_i & ~dc_stall;

    assign ld_use = valid_id_i & valid_ex_i & load_ex_i & we_ex_i
                  & (dst_ex_i != '0)
                  & ((dst_ex_i == src_a_id_i) | (dst_ex_i == src_b_id_i));

    assign raw_haz = (FWD_EN != 0) ? ld_use
                                   : (valid_id_i & (busy_a | busy_b));

    // A flushed ID instruction is dead, so it cannot stall.
    assign hazard = raw_haz & ~flush_i;

    assign block_if_o       = hazard | dc_stall | ic_stall;
    assign block_id_o       = hazard | dc_stall;
    assign block_ex_o       = dc_stall;
    assign block_mem_o      = dc_stall;
    assign inject_nops_wb_o = dc_stall;
    assign inject_nops_id_o = (ic_stall & ~block_id_o) | flush_eff;
    assign inject_nops_ex_o = (hazard & ~dc_stall) | flush_eff;

    assign issue  = valid_id_i & we_id_i & ~block_id_o & ~flush_i
                  & (dst_id_i != '0);
    assign retire = valid_wb_i & we_wb_i & ~block_wb & (dst_wb_i != '0);

    segre_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) u_sb (
        .clk_i      (clk_i),
        .rsn_i      (rsn_i),
        .issue      (issue),
        .issue_dst  (dst_id_i),
        .retire     (retire),
        .retire_dst (dst_wb_i),
        .src_a      (src_a_id_i),
        .src_b      (src_b_id_i),
        .busy_a     (busy_a),
        .busy_b     (busy_b)
    );

    assign ex_w  = valid_ex_i & we_ex_i;
    assign mem_w = valid_mem_i & we_mem_i;
    assign wb_w  = valid_wb_i & we_wb_i;

    always_comb begin
        fwd_a_o = FWD_NONE;
        fwd_b_o = FWD_NONE;
        if (FWD_EN != 0) begin
            fwd_a_o = fwd_pick(src_a_id_i, ex_w, dst_ex_i, mem_w,
                               dst_mem_i, wb_w, dst_wb_i);
            fwd_b_o = fwd_pick(src_b_id_i, ex_w, dst_ex_i, mem_w,
                               dst_mem_i, wb_w, dst_wb_i);
        end
    end

    // D-miss beats I-miss; a swallowed I-miss is remembered in ic_pend.
    always_comb begin
        state_n   = state;
        ic_pend_n = ic_pend;
        unique case (state)
            IDLE: begin
                if (d_miss) begin
                    state_n   = DC_MISS;
                    ic_pend_n = i_miss;
                end else if (i_miss) begin
                    state_n = IC_MISS;
                end
            end
            IC_MISS: begin
                if (d_miss) begin
                    state_n   = DC_MISS;
                    ic_pend_n = 1'b1;
                end else if (ic_fill_i) begin
                    state_n = IDLE;
                end
            end
            DC_MISS: begin
                if (dc_fill_i)
                    state_n = DC_REPLAY;
            end
            DC_REPLAY: begin
                state_n = (ic_pend & ~ic_fill_i) ? IC_MISS : IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (ic_fill_i)
            ic_pend_n = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state       <= IDLE;
            ic_pend     <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            state   <= state_n;
            ic_pend <= ic_pend_n;
            if (block_if_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_segre_hazard_ctrl.sv
// Bench for segre_hazard_ctrl: one instance per forwarding mode.
// Vector table plus hand-built multi-cycle sequences, checked via a queue.
module tb_segre_hazard_ctrl;
    import segre_pkg::*;

    typedef struct packed {
        logic       valid_if, ic_hit, ic_fill, valid_id, we_id;
        logic [4:0] src_a, src_b, dst_id;
        logic       valid_ex, we_ex, load_ex;
        logic [4:0] dst_ex;
        logic       valid_mem, we_mem, dc_miss, dc_fill;
        logic [4:0] dst_mem;
        logic       valid_wb, we_wb;
        logic [4:0] dst_wb;
        logic       flush;
    } in_t;

    typedef struct {
        in_t        i;
        logic       m;
        logic [6:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        string      name;
    } vec_t;

    localparam logic [6:0] C0   = 7'b0000000;
    localparam logic [6:0] CHAZ = 7'b1100010;
    localparam logic [6:0] CDC  = 7'b1111001;
    localparam logic [6:0] CIC  = 7'b1000100;
    localparam logic [6:0] CFL  = 7'b0000110;

    logic clk = 1'b0;
    logic rsn = 1'b0;
    logic valid_if, ic_hit, ic_fill, we_id;
    logic [1:0] valid_id, valid_wb;
    logic [4:0] src_a, src_b, dst_id, dst_ex, dst_mem, dst_wb;
    logic valid_ex, we_ex, load_ex, valid_mem, we_mem;
    logic dc_miss, dc_fill, we_wb, flush;
    logic [1:0] bif, bid, bex, bmem, nid, nex, nwb;
    fwd_sel_e fa0, fb0, fa1, fb1;
    logic [31:0] cnt0, cnt1;
    logic [6:0] ctl0, ctl1;

    int total = 0;
    int bad   = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign ctl0 = {bif[0], bid[0], bex[0], bmem[0], nid[0], nex[0], nwb[0]};
    assign ctl1 = {bif[1], bid[1], bex[1], bmem[1], nid[1], nex[1], nwb[1]};

    segre_hazard_ctrl #(.FWD_EN(0)) u_sb (
        .clk_i(clk), .rsn_i(rsn),
        .valid_if_i(valid_if), .ic_hit_i(ic_hit), .ic_fill_i(ic_fill),
        .valid_id_i(valid_id[0]), .we_id_i(we_id),
        .src_a_id_i(src_a), .src_b_id_i(src_b), .dst_id_i(dst_id),
        .valid_ex_i(valid_ex), .we_ex_i(we_ex), .load_ex_i(load_ex),
        .dst_ex_i(dst_ex),
        .valid_mem_i(valid_mem), .we_mem_i(we_mem), .dc_miss_i(dc_miss),
        .dc_fill_i(dc_fill), .dst_mem_i(dst_mem),
        .valid_wb_i(valid_wb[0]), .we_wb_i(we_wb), .dst_wb_i(dst_wb),
        .flush_i(flush),
        .block_if_o(bif[0]), .block_id_o(bid[0]), .block_ex_o(bex[0]),
        .block_mem_o(bmem[0]), .inject_nops_id_o(nid[0]),
        .inject_nops_ex_o(nex[0]), .inject_nops_wb_o(nwb[0]),
        .fwd_a_o(fa0), .fwd_b_o(fb0), .stall_cnt_o(cnt0)
    );

    segre_hazard_ctrl #(.FWD_EN(1)) u_fw (
        .clk_i(clk), .rsn_i(rsn),
        .valid_if_i(valid_if), .ic_hit_i(ic_hit), .ic_fill_i(ic_fill),
        .valid_id_i(valid_id[1]), .we_id_i(we_id),
        .src_a_id_i(src_a), .src_b_id_i(src_b), .dst_id_i(dst_id),
        .valid_ex_i(valid_ex), .we_ex_i(we_ex), .load_ex_i(load_ex),
        .dst_ex_i(dst_ex),
        .valid_mem_i(valid_mem), .we_mem_i(we_mem), .dc_miss_i(dc_miss),
        .dc_fill_i(dc_fill), .dst_mem_i(dst_mem),
        .valid_wb_i(valid_wb[1]), .we_wb_i(we_wb), .dst_wb_i(dst_wb),
        .flush_i(flush),
        .block_if_o(bif[1]), .block_id_o(bid[1]), .block_ex_o(bex[1]),
        .block_mem_o(bmem[1]), .inject_nops_id_o(nid[1]),
        .inject_nops_ex_o(nex[1]), .inject_nops_wb_o(nwb[1]),
        .fwd_a_o(fa1), .fwd_b_o(fb1), .stall_cnt_o(cnt1)
    );

    function automatic in_t nop();
        in_t t;
        t = '0;
        t.valid_if = 1'b1;
        t.ic_hit = 1'b1;
        return t;
    endfunction

    function automatic vec_t mk(input in_t i, input logic m,
                                input logic [6:0] ctl, input fwd_sel_e a,
                                input fwd_sel_e b, input string n);
        vec_t v;
        v.i = i; v.m = m; v.ctl = ctl; v.fa = a; v.fb = b; v.name = n;
        return v;
    endfunction

    // ID and WB validity go only to the instance under test so the
    // other instance never issues or retires behind the bench's back.
    task automatic drive(input in_t t, input logic m);
        valid_if = t.valid_if; ic_hit = t.ic_hit; ic_fill = t.ic_fill;
        valid_id = m ? {t.valid_id, 1'b0} : {1'b0, t.valid_id};
        we_id = t.we_id; src_a = t.src_a; src_b = t.src_b;
        dst_id = t.dst_id; valid_ex = t.valid_ex; we_ex = t.we_ex;
        load_ex = t.load_ex; dst_ex = t.dst_ex;
        valid_mem = t.valid_mem; we_mem = t.we_mem;
        dc_miss = t.dc_miss; dc_fill = t.dc_fill; dst_mem = t.dst_mem;
        valid_wb = m ? {t.valid_wb, 1'b0} : {1'b0, t.valid_wb};
        we_wb = t.we_wb; dst_wb = t.dst_wb; flush = t.flush;
    endtask

    task automatic chk();
        vec_t e;
        logic [6:0] c;
        logic [1:0] a, b;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL queue_empty got=none want=entry");
            return;
        end
        e = exp_q.pop_front();
        c = e.m ? ctl1 : ctl0;
        a = e.m ? fa1 : fa0;
        b = e.m ? fb1 : fb0;
        if (c !== e.ctl || a !== e.fa || b !== e.fb) begin
            bad++;
            $display("FAIL %s got ctl=%b fa=%0d fb=%0d want ctl=%b fa=%0d fb=%0d",
                     e.name, c, a, b, e.ctl, e.fa, e.fb);
        end
    endtask

    task automatic chk_val(input string n, input logic [31:0] act,
                           input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", n, act, want);
        end
    endtask

    task automatic run(input vec_t v);
        drive(v.i, v.m);
        exp_q.push_back(v);
        @(negedge clk);
        chk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(nop(), 1'b0);
        rsn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rsn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        in_t t;

        t = nop(); tbl.push_back(mk(t, 1, C0, FWD_NONE, FWD_NONE, "idle"));
        t = nop(); t.valid_id = 1; t.src_a = 7;
        t.valid_ex = 1; t.we_ex = 1; t.load_ex = 1; t.dst_ex = 7;
        tbl.push_back(mk(t, 1, CHAZ, FWD_EX, FWD_NONE, "load_use_a"));
        t.load_ex = 0;
        tbl.push_back(mk(t, 1, C0, FWD_EX, FWD_NONE, "alu_ex_a"));
        t = nop(); t.valid_id = 1; t.src_b = 3;
        t.valid_mem = 1; t.we_mem = 1; t.dst_mem = 3;
        tbl.push_back(mk(t, 1, C0, FWD_NONE, FWD_MEM, "mem_b"));
        t = nop(); t.valid_id = 1; t.we_id = 1; t.dst_id = 12;
        tbl.push_back(mk(t, 1, C0, FWD_NONE, FWD_NONE, "issue_x12"));
        t = nop(); t.valid_id = 1; t.src_a = 12;
        t.valid_wb = 1; t.we_wb = 1; t.dst_wb = 12;
        tbl.push_back(mk(t, 1, C0, FWD_WB, FWD_NONE, "wb_a"));
        t = nop(); t.valid_id = 1; t.src_a = 4; t.src_b = 4;
        t.valid_ex = 1; t.we_ex = 1; t.dst_ex = 4;
        t.valid_mem = 1; t.we_mem = 1; t.dst_mem = 4;
        tbl.push_back(mk(t, 1, C0, FWD_EX, FWD_EX, "ex_over_mem"));
        t = nop(); t.valid_id = 1; t.we_id = 1; t.dst_id = 5;
        tbl.push_back(mk(t, 1, C0, FWD_NONE, FWD_NONE, "issue_x5"));
        t = nop(); t.valid_id = 1; t.src_a = 5;
        t.valid_mem = 1; t.we_mem = 1; t.dst_mem = 5;
        t.valid_wb = 1; t.we_wb = 1; t.dst_wb = 5;
        tbl.push_back(mk(t, 1, C0, FWD_MEM, FWD_NONE, "mem_over_wb"));
        t = nop(); t.valid_id = 1;
        t.valid_ex = 1; t.we_ex = 1; t.dst_ex = 0;
        tbl.push_back(mk(t, 1, C0, FWD_NONE, FWD_NONE, "src_x0"));
        t = nop(); t.valid_id = 1; t.src_a = 1; t.src_b = 4;
        t.valid_ex = 1; t.we_ex = 1; t.load_ex = 1; t.dst_ex = 4;
        tbl.push_back(mk(t, 1, CHAZ, FWD_NONE, FWD_EX, "load_use_b"));
        t = nop(); t.valid_id = 1;
        t.valid_ex = 1; t.we_ex = 1; t.load_ex = 1; t.dst_ex = 0;
        tbl.push_back(mk(t, 1, C0, FWD_NONE, FWD_NONE, "load_x0"));
        t = nop(); t.valid_id = 1; t.src_a = 7;
        t.valid_ex = 1; t.load_ex = 1; t.dst_ex = 7;
        tbl.push_back(mk(t, 1, C0, FWD_NONE, FWD_NONE, "load_no_we"));
        t = nop(); t.valid_id = 1; t.we_id = 1; t.dst_id = 9; t.flush = 1;
        tbl.push_back(mk(t, 1, CFL, FWD_NONE, FWD_NONE, "flush_fw"));
        t = nop(); t.valid_id = 1; t.src_a = 7;
        t.valid_ex = 1; t.we_ex = 1; t.load_ex = 1; t.dst_ex = 7;
        tbl.push_back(mk(t, 0, C0, FWD_NONE, FWD_NONE, "sb_mode_no_fwd"));

        do_reset();
        #1;
        exp_q.push_back(mk(nop(), 0, C0, FWD_NONE, FWD_NONE, "reset_sb"));
        chk();
        exp_q.push_back(mk(nop(), 1, C0, FWD_NONE, FWD_NONE, "reset_fw"));
        chk();
        chk_val("reset_cnt", cnt0, 0);

        foreach (tbl[k])
            run(tbl[k]);

        // Scoreboard mode: RAW on x5 stalls until x5 retires.
        do_reset();
        t = nop(); t.valid_id = 1; t.we_id = 1; t.dst_id = 5;
        t.src_a = 1; t.src_b = 2;
        run(mk(t, 0, C0, FWD_NONE, FWD_NONE, "raw_issue"));
        t = nop(); t.valid_id = 1; t.we_id = 1; t.dst_id = 6; t.src_a = 5;
        t.valid_ex = 1; t.we_ex = 1; t.dst_ex = 5;
        run(mk(t, 0, CHAZ, FWD_NONE, FWD_NONE, "raw_stall1"));
        t.valid_ex = 0; t.valid_mem = 1; t.we_mem = 1; t.dst_mem = 5;
        run(mk(t, 0, CHAZ, FWD_NONE, FWD_NONE, "raw_stall2"));
        t.valid_mem = 0; t.valid_wb = 1; t.we_wb = 1; t.dst_wb = 5;
        run(mk(t, 0, CHAZ, FWD_NONE, FWD_NONE, "raw_stall3"));
        t.valid_wb = 0;
        run(mk(t, 0, C0, FWD_NONE, FWD_NONE, "raw_release"));
        t = nop(); t.valid_id = 1; t.src_a = 6;
        t.valid_wb = 1; t.we_wb = 1; t.dst_wb = 6;
        run(mk(t, 0, CHAZ, FWD_NONE, FWD_NONE, "retire_same_cycle"));
        t.valid_wb = 0;
        run(mk(t, 0, C0, FWD_NONE, FWD_NONE, "retired_x6"));

        // Forwarding mode: one load-use bubble, then MEM forward.
        do_reset();
        t = nop(); t.valid_id = 1; t.src_a = 7;
        t.valid_ex = 1; t.we_ex = 1; t.load_ex = 1; t.dst_ex = 7;
        run(mk(t, 1, CHAZ, FWD_EX, FWD_NONE, "lu_stall"));
        t.valid_ex = 0; t.valid_mem = 1; t.we_mem = 1; t.dst_mem = 7;
        run(mk(t, 1, C0, FWD_MEM, FWD_NONE, "lu_fwd_mem"));

        // D-miss held 10 cycles, fill, replay, release.
        do_reset();
        chk_val("cnt_after_reset", cnt1, 0);
        t = nop(); t.valid_mem = 1; t.dc_miss = 1;
        for (int k = 0; k < 10; k++)
            run(mk(t, 0, CDC, FWD_NONE, FWD_NONE, "dm_wait"));
        t = nop(); t.dc_fill = 1;
        run(mk(t, 0, CDC, FWD_NONE, FWD_NONE, "dm_fill"));
        run(mk(nop(), 0, CDC, FWD_NONE, FWD_NONE, "dm_replay"));
        run(mk(nop(), 0, C0, FWD_NONE, FWD_NONE, "dm_release"));
        chk_val("dm_cnt_sb", cnt0, 12);
        chk_val("dm_cnt_fw", cnt1, 12);

        // I-miss and D-miss together: D first, then the pending I-miss.
        do_reset();
        t = nop(); t.ic_hit = 0; t.valid_mem = 1; t.dc_miss = 1;
        run(mk(t, 0, CDC, FWD_NONE, FWD_NONE, "both_miss"));
        t = nop(); t.ic_hit = 0; t.dc_fill = 1;
        run(mk(t, 0, CDC, FWD_NONE, FWD_NONE, "both_dfill"));
        t = nop(); t.ic_hit = 0;
        run(mk(t, 0, CDC, FWD_NONE, FWD_NONE, "both_replay"));
        run(mk(t, 0, CIC, FWD_NONE, FWD_NONE, "both_ic_wait"));
        t.ic_fill = 1;
        run(mk(t, 0, CIC, FWD_NONE, FWD_NONE, "both_ic_fill"));
        run(mk(nop(), 0, C0, FWD_NONE, FWD_NONE, "both_idle"));

        // Flush kills the x9 writer; a D-miss overrides a flush.
        do_reset();
        t = nop(); t.valid_id = 1; t.we_id = 1; t.dst_id = 9; t.flush = 1;
        run(mk(t, 0, CFL, FWD_NONE, FWD_NONE, "flush_x9"));
        t = nop(); t.valid_id = 1; t.src_a = 9;
        run(mk(t, 0, C0, FWD_NONE, FWD_NONE, "x9_not_busy"));
        t = nop(); t.valid_id = 1; t.we_id = 1; t.dst_id = 9; t.flush = 1;
        t.valid_mem = 1; t.dc_miss = 1;
        run(mk(t, 0, CDC, FWD_NONE, FWD_NONE, "dmiss_over_flush"));
        t = nop(); t.dc_fill = 1;
        run(mk(t, 0, CDC, FWD_NONE, FWD_NONE, "flush_dfill"));
        run(mk(nop(), 0, CDC, FWD_NONE, FWD_NONE, "flush_replay"));
        t = nop(); t.valid_id = 1; t.src_a = 9;
        run(mk(t, 0, C0, FWD_NONE, FWD_NONE, "x9_still_free"));

        // Async reset in the middle of a D-miss.
        do_reset();
        t = nop(); t.valid_id = 1; t.we_id = 1; t.dst_id = 5;
        run(mk(t, 0, C0, FWD_NONE, FWD_NONE, "pre_issue_x5"));
        t = nop(); t.valid_mem = 1; t.dc_miss = 1;
        run(mk(t, 0, CDC, FWD_NONE, FWD_NONE, "pre_dmiss"));
        #2;
        drive(nop(), 1'b0);
        rsn = 1'b0;
        #1;
        exp_q.push_back(mk(nop(), 0, C0, FWD_NONE, FWD_NONE, "async_rst"));
        chk();
        chk_val("async_rst_cnt", cnt0, 0);
        @(posedge clk);
        #1 rsn = 1'b1;
        t = nop(); t.valid_id = 1; t.src_a = 5;
        run(mk(t, 0, C0, FWD_NONE, FWD_NONE, "sb_clear_after_rst"));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
